// File: rtl/max_pooling_pkg.sv
// rtl/max_pooling_pkg.sv - shared defaults and elaboration-time sizing helpers for max_pooling
package max_pooling_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_SIZE  = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int window_elems(input int size);
    return size * size;
  endfunction

  // A single-element window still goes through one register stage.
  function automatic int pool_latency(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int k = 0; k < lvl; k++) begin
      c = (c + 1) / 2;
    end
    return c;
  endfunction

endpackage

// File: rtl/max_pool_cmp2.sv
// rtl/max_pool_cmp2.sv - registered 2-input max with valid pass-through
// Signed compare when MAXPOOL_SIGNED_EN is defined, unsigned otherwise.
module max_pool_cmp2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] max_o,
  output logic             valid_o
);

  logic             a_ge_b;
  logic [WIDTH-1:0] max_d;
  logic [WIDTH-1:0] max_q;
  logic             valid_q;

`ifdef MAXPOOL_SIGNED_EN
  assign a_ge_b = $signed(a_i) >= $signed(b_i);
`else
  assign a_ge_b = a_i >= b_i;
`endif

  assign max_d = a_ge_b ? a_i : b_i;

  // Data only loads on valid slots so bubbles leave the last result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        max_q <= max_d;
      end
    end
  end

  assign max_o   = max_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/max_pooling.sv
// rtl/max_pooling.sv - pipelined SIZE x SIZE max-pooling comparator tree, one window per clock
// Optional MAXPOOL_SIGNED_EN selects two's complement elements (handled in max_pool_cmp2).
module max_pooling
  import max_pooling_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SIZE  = DEFAULT_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [SIZE*SIZE*WIDTH-1:0]   i_matrix,
  output logic [WIDTH-1:0]             o_max_pool,
  output logic                         o_valid
);

  localparam int N = window_elems(SIZE);
  localparam int L = pool_latency(N);

  for (genvar l = 1; l <= L; l++) begin : g_lvl
    localparam int CNT_IN  = level_count(N, l - 1);
    localparam int CNT_OUT = level_count(N, l);

    logic [CNT_IN*WIDTH-1:0]  din;
    logic                     vin;
    logic [CNT_OUT*WIDTH-1:0] dout;
    logic [CNT_OUT-1:0]       v_vec;
    logic                     vout;

    if (l == 1) begin : g_src
      assign din = i_matrix;
      assign vin = en;
    end else begin : g_src
      assign din = g_lvl[l-1].dout;
      assign vin = g_lvl[l-1].vout;
    end

    for (genvar i = 0; i < CNT_IN / 2; i++) begin : g_pair
      max_pool_cmp2 #(.WIDTH(WIDTH)) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .valid_i (vin),
        .a_i     (din[(2*i)*WIDTH +: WIDTH]),
        .b_i     (din[(2*i+1)*WIDTH +: WIDTH]),
        .max_o   (dout[i*WIDTH +: WIDTH]),
        .valid_o (v_vec[i])
      );
    end

    if (CNT_IN % 2 == 1) begin : g_odd
      logic [WIDTH-1:0] pass_q;
      logic             pass_v_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          pass_q   <= '0;
          pass_v_q <= 1'b0;
        end else begin
          pass_v_q <= vin;
          if (vin) begin
            pass_q <= din[(CNT_IN-1)*WIDTH +: WIDTH];
          end
        end
      end

      assign dout[(CNT_OUT-1)*WIDTH +: WIDTH] = pass_q;
      assign v_vec[CNT_OUT-1]                 = pass_v_q;
    end

    // Every lane of a level carries the same valid bit.
    assign vout = |v_vec;
  end

  assign o_max_pool = g_lvl[L].dout;
  assign o_valid    = g_lvl[L].vout;

endmodule

// File: tb/tb_max_pooling.sv
// tb/tb_max_pooling.sv - scoreboard bench for max_pooling (WIDTH=8, SIZE=2)
module tb_max_pooling;

  localparam int W   = 8;
  localparam int S   = 2;
  localparam int N   = 4;
  localparam int LAT = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic [N*W-1:0]   i_matrix;
  logic [W-1:0]     o_max_pool;
  logic             o_valid;

  typedef struct {
    logic [W-1:0] val;
    int           due;
  } exp_t;

  typedef logic [W-1:0] win_t [N];

  exp_t         sb[$];
  int           checks;
  int           errors;
  int           cyc;
  bit           mon_en;
  logic [W-1:0] last_exp;

  max_pooling #(.WIDTH(W), .SIZE(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i_matrix   (i_matrix),
    .o_max_pool (o_max_pool),
    .o_valid    (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_max(input win_t e);
    logic [W-1:0] best;
    best = e[0];
    for (int k = 1; k < N; k++) begin
`ifdef MAXPOOL_SIGNED_EN
      if ($signed(e[k]) > $signed(best)) best = e[k];
`else
      if (e[k] > best) best = e[k];
`endif
    end
    return best;
  endfunction

  task automatic send(input win_t e, input logic [W-1:0] exp_val);
    exp_t item;
    @(posedge clk);
    #1;
    en = 1'b1;
    for (int k = 0; k < N; k++) i_matrix[k*W +: W] = e[k];
    item.val = exp_val;
    item.due = cyc + LAT;
    sb.push_back(item);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      en = 1'b0;
      i_matrix = $urandom;
    end
  endtask

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (o_valid) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid got=%0h want=no_pulse cyc=%0d", o_max_pool, cyc);
        end else begin
          exp_t item;
          item = sb.pop_front();
          if (o_max_pool !== item.val || cyc != item.due) begin
            errors++;
            $display("FAIL result got=%0h@%0d want=%0h@%0d", o_max_pool, cyc, item.val, item.due);
          end
          last_exp = item.val;
        end
      end else begin
        if (o_max_pool !== last_exp) begin
          errors++;
          $display("FAIL hold got=%0h want=%0h cyc=%0d", o_max_pool, last_exp, cyc);
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
          errors++;
          $display("FAIL missing_valid got=none want=%0h@%0d", sb[0].val, sb[0].due);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    win_t w;
    logic [W-1:0] signed_exp;
    checks   = 0;
    errors   = 0;
    mon_en   = 1'b0;
    last_exp = '0;
    rst      = 1'b1;
    en       = 1'b0;
    i_matrix = '1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_valid", {7'd0, o_valid}, 8'd0);
    check("reset_max", o_max_pool, 8'd0);
    mon_en = 1'b1;

    w = '{8'd25, 8'd56, 8'd12, 8'd200};
    send(w, 8'd200);
    idle(4);

    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < N; k++) w[k] = 8'h01;
      w[p] = 8'hFF;
      send(w, 8'hFF);
    end
    w = '{8'h7A, 8'h7A, 8'h7A, 8'h7A};
    send(w, 8'h7A);
    idle(3);

    w = '{8'd1, 8'd2, 8'd3, 8'd4};
    send(w, 8'd4);
    w = '{8'd9, 8'd0, 8'd0, 8'd0};
    send(w, 8'd9);
    w = '{8'd5, 8'd5, 8'd5, 8'd5};
    send(w, 8'd5);
    idle(3);

    w = '{8'd3, 8'd1, 8'd2, 8'd0};
    send(w, 8'd3);
    idle(1);
    w = '{8'd0, 8'd0, 8'd0, 8'd8};
    send(w, 8'd8);
    idle(3);

`ifdef MAXPOOL_SIGNED_EN
    signed_exp = 8'h38;
`else
    signed_exp = 8'hFF;
`endif
    w = '{8'hC8, 8'h38, 8'h0C, 8'hFF};
    send(w, signed_exp);
    idle(3);

    w = '{8'd10, 8'd20, 8'd30, 8'd40};
    send(w, 8'd40);
    @(posedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    sb.delete();
    last_exp = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(LAT + 2);
    check("midreset_max", o_max_pool, 8'd0);

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) < 7) begin
        for (int k = 0; k < N; k++) w[k] = W'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          for (int k = 0; k < N; k++) w[k] = w[0];
        end
        send(w, ref_max(w));
      end else begin
        idle(1);
      end
    end
    idle(1);

    for (int t = 0; t < 20 && sb.size() > 0; t++) idle(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
